// File: rtl/dumbrv_fetch_if.sv
`default_nettype none
// ============================================================================
//  Module      : dumbrv_fetch_if
//  Description : Core-side instruction/redirect bus and byte-reader bus for
//                the dumbrv instruction fetch front-end.
//  Revision    : 1.0
// ============================================================================
interface dumbrv_fetch_if;
    logic        redirect_i;
    logic [15:0] redirect_pc_i;
    logic        instr_valid_o;
    logic [31:0] instr_o;
    logic [15:0] instr_pc_o;
    logic        instr_ready_i;
    logic        mem_valid_o;
    logic [15:0] mem_addr_o;
    logic        mem_done_i;
    logic [7:0]  mem_data_i;

    // master: the fetch unit itself
    modport master (
        input  redirect_i, redirect_pc_i, instr_ready_i, mem_done_i, mem_data_i,
        output instr_valid_o, instr_o, instr_pc_o, mem_valid_o, mem_addr_o
    );

    // slave: the core and the SPI byte reader surrounding the fetch unit
    modport slave (
        output redirect_i, redirect_pc_i, instr_ready_i, mem_done_i, mem_data_i,
        input  instr_valid_o, instr_o, instr_pc_o, mem_valid_o, mem_addr_o
    );
endinterface
`default_nettype wire

// File: rtl/dumbrv_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : dumbrv_fetch
//  Description : Byte-serial instruction fetch; assembles 4 little-endian
//                bytes per instruction and prefetches while the core stalls.
//  Revision    : 1.0
// ============================================================================
module dumbrv_fetch #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    dumbrv_fetch_if.master     bus
);

    typedef enum logic [1:0] {
        ST_GAP  = 2'd0,
        ST_REQ  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    state_t      r_state;
    logic [1:0]  r_idx;
    logic [15:0] r_fetch_pc;
    logic [31:0] r_asm;

    logic [15:0] w_byte_addr;
    logic [15:0] w_next_pc;
    logic        w_slot_free;

    assign w_byte_addr = r_fetch_pc + {14'd0, r_idx};
    assign w_next_pc   = r_fetch_pc + 16'd4;
    assign w_slot_free = !bus.instr_valid_o || bus.instr_ready_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state           <= ST_GAP;
            r_idx             <= 2'd0;
            r_fetch_pc        <= RESET_PC;
            r_asm             <= 32'd0;
            bus.instr_valid_o <= 1'b0;
            bus.instr_o       <= 32'd0;
            bus.instr_pc_o    <= 16'd0;
            bus.mem_valid_o   <= 1'b0;
            bus.mem_addr_o    <= RESET_PC;
        end else if (bus.redirect_i) begin
            // Dropping mem_valid_o aborts the reader; GAP guarantees the low cycle.
            r_state           <= ST_GAP;
            r_idx             <= 2'd0;
            r_fetch_pc        <= bus.redirect_pc_i;
            bus.mem_valid_o   <= 1'b0;
            bus.instr_valid_o <= 1'b0;
        end else begin
            if (bus.instr_valid_o && bus.instr_ready_i) begin
                bus.instr_valid_o <= 1'b0;
            end

            case (r_state)
                ST_GAP: begin
                    bus.mem_valid_o <= 1'b1;
                    bus.mem_addr_o  <= w_byte_addr;
                    r_state         <= ST_REQ;
                end

                ST_REQ: begin
                    if (bus.mem_done_i) begin
                        r_asm[{r_idx, 3'b000} +: 8] <= bus.mem_data_i;
                        bus.mem_valid_o             <= 1'b0;
                        if (r_idx != 2'd3) begin
                            r_idx   <= r_idx + 2'd1;
                            r_state <= ST_GAP;
                        end else if (w_slot_free) begin
                            bus.instr_valid_o <= 1'b1;
                            bus.instr_o       <= {bus.mem_data_i, r_asm[23:0]};
                            bus.instr_pc_o    <= r_fetch_pc;
                            r_fetch_pc        <= w_next_pc;
                            r_idx             <= 2'd0;
                            r_state           <= ST_GAP;
                        end else begin
                            r_state <= ST_HOLD;
                        end
                    end
                end

                ST_HOLD: begin
                    // mem_valid_o has been low since entry, so the next request
                    // can start on the same edge the held instruction moves out.
                    if (bus.instr_ready_i) begin
                        bus.instr_valid_o <= 1'b1;
                        bus.instr_o       <= r_asm;
                        bus.instr_pc_o    <= r_fetch_pc;
                        r_fetch_pc        <= w_next_pc;
                        r_idx             <= 2'd0;
                        bus.mem_valid_o   <= 1'b1;
                        bus.mem_addr_o    <= w_next_pc;
                        r_state           <= ST_REQ;
                    end
                end

                default: begin
                    bus.mem_valid_o <= 1'b0;
                    r_state         <= ST_GAP;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
